// File: rtl/pulse_capture.sv
// pulse_capture: measures high time and period of a synchronized pulse line into a one-entry result buffer
module pulse_capture #(
  parameter int CntWidth   = 32,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                pulse_i,
  output logic                meas_valid_o,
  input  logic                meas_ready_i,
  output logic [CntWidth-1:0] high_cnt_o,
  output logic [CntWidth-1:0] period_cnt_o,
  output logic                timeout_o,
  output logic                overrun_o,
  input  logic                clear_i
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CntWidth-1:0] MaxCnt = '1;
  state_t                r_state;
  logic [SyncStages-1:0] r_sync;
  logic                  r_s_q;
  logic [CntWidth-1:0]   r_cnt;
  logic [CntWidth-1:0]   r_high_q;
  logic                  w_s;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_sat;
  logic                  w_emit;
  logic                  w_load;
  logic                  w_timeout;
  logic [CntWidth-1:0]   w_cnt_inc;
  logic [CntWidth-1:0]   w_high;
  logic [CntWidth-1:0]   w_period;

  assign w_s       = r_sync[SyncStages-1];
  assign w_rise    = w_s & ~r_s_q;
  assign w_fall    = ~w_s & r_s_q;
  assign w_sat     = r_cnt == MaxCnt;
  assign w_cnt_inc = w_sat ? r_cnt : r_cnt + 1'b1;
  // a closing rise in LOW is the only non-timeout result; everything else is a saturation exit
  assign w_emit    = en_i & (((r_state == HIGH) & ~w_fall & w_sat) | ((r_state == LOW) & (w_rise | w_sat)));
  assign w_timeout = ~((r_state == LOW) & w_rise);
  assign w_high    = (r_state == HIGH) ? MaxCnt : r_high_q;
  assign w_period  = w_timeout ? MaxCnt : r_cnt;
  assign w_load    = w_emit & (~meas_valid_o | meas_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_s_q  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], pulse_i};
      r_s_q  <= w_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_high_q <= '0;
    end else if (!en_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_cnt   <= CntWidth'(1);
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_state  <= LOW;
            r_high_q <= r_cnt;
            r_cnt    <= w_cnt_inc;
          end else if (w_sat) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_cnt   <= CntWidth'(1);
          end else if (w_sat) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meas_valid_o <= 1'b0;
      high_cnt_o   <= '0;
      period_cnt_o <= '0;
      timeout_o    <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (w_load) begin
        meas_valid_o <= 1'b1;
        high_cnt_o   <= w_high;
        period_cnt_o <= w_period;
        timeout_o    <= w_timeout;
      end else if (meas_valid_o & meas_ready_i) begin
        meas_valid_o <= 1'b0;
      end
      if (w_emit & ~w_load) overrun_o <= 1'b1;
      else if (clear_i) overrun_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: timestamp-based reference model checked every cycle on a 32-bit and a 4-bit instance
module tb_pulse_capture;
  localparam int SS = 2;
  typedef struct {longint h; longint p; bit t;} res_t;
  logic        clk = 1'b0;
  logic        rst, en, pulse, ready, clear;
  logic        v32, to32, ov32, v4, to4, ov4;
  logic [31:0] hi32, per32;
  logic [3:0]  hi4, per4;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  bit          chk_on = 1'b0;
  longint      n = 0;
  bit          pad_hist[$];
  res_t        q32[$];
  res_t        q4[$];
  longint      m_max[2] = '{64'hFFFF_FFFF, 15};
  longint      t_rise[2], t_fall[2], bh[2], bp[2];
  bit          mv[2], bt[2], mov[2];

  pulse_capture #(.CntWidth(32), .SyncStages(SS)) dut32 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pulse_i(pulse), .meas_valid_o(v32), .meas_ready_i(ready),
    .high_cnt_o(hi32), .period_cnt_o(per32), .timeout_o(to32), .overrun_o(ov32), .clear_i(clear));
  pulse_capture #(.CntWidth(4), .SyncStages(SS)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pulse_i(pulse), .meas_valid_o(v4), .meas_ready_i(ready),
    .high_cnt_o(hi4), .period_cnt_o(per4), .timeout_o(to4), .overrun_o(ov4), .clear_i(clear));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit seen(int k);
    return (pad_hist.size() > k) ? pad_hist[pad_hist.size() - 1 - k] : 1'b0;
  endfunction

  task automatic model_reset();
    pad_hist.delete();
    for (int i = 0; i < 2; i++) begin
      t_rise[i] = -1; t_fall[i] = -1; bh[i] = 0; bp[i] = 0; mv[i] = 0; bt[i] = 0; mov[i] = 0;
    end
  endtask

  // A measurement is a rise timestamp plus an optional fall timestamp; results are timestamp differences.
  task automatic model_step();
    bit r, f, emit, et, drop;
    longint eh, ep;
    pad_hist.push_back(pulse);
    r = seen(SS) & ~seen(SS + 1);
    f = ~seen(SS) & seen(SS + 1);
    for (int i = 0; i < 2; i++) begin
      emit = 0; et = 0; eh = 0; ep = 0;
      if (!en) t_rise[i] = -1;
      else if (t_rise[i] < 0) begin
        if (r) begin t_rise[i] = n; t_fall[i] = -1; end
      end else if (t_fall[i] < 0) begin
        if (f) t_fall[i] = n;
        else if (n - t_rise[i] >= m_max[i]) begin
          emit = 1; et = 1; eh = m_max[i]; ep = m_max[i]; t_rise[i] = -1;
        end
      end else begin
        if (r) begin
          emit = 1; eh = t_fall[i] - t_rise[i]; ep = n - t_rise[i]; t_rise[i] = n; t_fall[i] = -1;
        end else if (n - t_rise[i] >= m_max[i]) begin
          emit = 1; et = 1; eh = t_fall[i] - t_rise[i]; ep = m_max[i]; t_rise[i] = -1;
        end
      end
      drop = emit && mv[i] && !ready;
      if (drop) mov[i] = 1;
      else if (clear) mov[i] = 0;
      if (emit && !drop) begin
        mv[i] = 1; bh[i] = eh; bp[i] = ep; bt[i] = et;
      end else if (!emit && mv[i] && ready) mv[i] = 0;
    end
    n++;
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("valid32", v32, mv[0]);
      check("overrun32", ov32, mov[0]);
      if (mv[0]) begin
        check("high32", hi32, bh[0]);
        check("period32", per32, bp[0]);
        check("timeout32", to32, bt[0]);
      end
      check("valid4", v4, mv[1]);
      check("overrun4", ov4, mov[1]);
      if (mv[1]) begin
        check("high4", hi4, bh[1]);
        check("period4", per4, bp[1]);
        check("timeout4", to4, bt[1]);
      end
    end
  end

  task automatic tick();
    if (v32 && ready) q32.push_back('{h: hi32, p: per32, t: to32});
    if (v4 && ready) q4.push_back('{h: hi4, p: per4, t: to4});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit p, input int k);
    pulse = p;
    repeat (k) tick();
  endtask

  task automatic abort();
    en = 0;
    tick();
    tick();
    en = 1;
  endtask

  task automatic check_q(input string name, input res_t q[$], input int cnt, input longint h, input longint p, input bit t);
    check({name, "_count"}, q.size(), cnt);
    foreach (q[i]) begin
      check({name, "_high"}, q[i].h, h);
      check({name, "_period"}, q[i].p, p);
      check({name, "_timeout"}, q[i].t, t);
    end
  endtask

  initial begin
    rst = 1; en = 0; pulse = 0; ready = 0; clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", v32, 0); check("rst_high", hi32, 0); check("rst_period", per32, 0);
    check("rst_timeout", to32, 0); check("rst_overrun", ov32, 0); check("rst_valid4", v4, 0);
    rst = 0; chk_on = 1;
    // H=3 L=5 PWM; valid appears in the 4th cycle counting the closing pad edge cycle as 1
    en = 1; ready = 1;
    drive(0, 4);
    drive(1, 3); drive(0, 5);
    pulse = 1;
    tick(); check("lat_c2", v32, 0);
    tick(); check("lat_c3", v32, 0);
    tick(); check("lat_c4", v32, 1);
    drive(0, 5);
    repeat (2) begin drive(1, 3); drive(0, 5); end
    abort();
    check_q("pwm38", q32, 3, 3, 8, 0);
    // fastest legal square wave
    q32.delete();
    drive(0, 3);
    repeat (8) begin drive(1, 1); drive(0, 1); end
    drive(0, 3);
    abort();
    check_q("sq11", q32, 7, 1, 2, 0);
    check("sq11_overrun", ov32, 0);
    // full buffer drops the second result and sets overrun
    ready = 0;
    drive(0, 3);
    repeat (3) begin drive(1, 2); drive(0, 2); end
    drive(0, 2);
    check("held_valid", v32, 1); check("held_high", hi32, 2); check("held_period", per32, 4);
    check("held_timeout", to32, 0); check("held_overrun", ov32, 1);
    clear = 1; tick(); clear = 0;
    check("cleared_overrun", ov32, 0);
    abort();
    drive(0, 2); drive(1, 2); drive(0, 2);
    pulse = 1;
    tick(); tick();
    clear = 1; tick(); clear = 0;
    check("set_wins32", ov32, 1);
    check("set_wins4", ov4, 1);
    drive(1, 1); drive(0, 2);
    ready = 1;
    abort();
    clear = 1; tick(); clear = 0;
    check("drained_valid", v32, 0); check("drained_overrun", ov32, 0);
    // saturation on the 4-bit instance: stuck high, then long low
    q32.delete(); q4.delete();
    drive(0, 3); drive(1, 20); drive(0, 4); drive(1, 3); drive(0, 20);
    abort();
    check("sat4_count", q4.size(), 2);
    if (q4.size() == 2) begin
      check("sat4_a_high", q4[0].h, 15); check("sat4_a_period", q4[0].p, 15); check("sat4_a_to", q4[0].t, 1);
      check("sat4_b_high", q4[1].h, 3); check("sat4_b_period", q4[1].p, 15); check("sat4_b_to", q4[1].t, 1);
    end
    check_q("long32", q32, 1, 20, 24, 0);
    // enable drop mid-HIGH, re-enable with line high, then async reset in LOW
    ready = 0;
    drive(0, 3); drive(1, 4);
    en = 0; tick(); en = 1;
    drive(1, 5);
    check("reen_high_noresult", v32, 0);
    drive(0, 3);
    repeat (3) begin drive(1, 2); drive(0, 2); end
    drive(0, 1);
    check("reen_valid", v32, 1); check("reen_high", hi32, 2); check("reen_period", per32, 4);
    check("reen_overrun", ov32, 1);
    #2 rst = 1;
    #1;
    model_reset();
    check("arst_valid", v32, 0); check("arst_high", hi32, 0); check("arst_period", per32, 0);
    check("arst_timeout", to32, 0); check("arst_overrun", ov32, 0);
    check("arst_valid4", v4, 0); check("arst_overrun4", ov4, 0);
    @(negedge clk);
    rst = 0;
    drive(0, 3); drive(1, 3); drive(0, 3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
